// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: sequences loads/stores over a req/ack data-memory
// handshake and drives MEM/WB write-enable/bubble/data. Optional feature: MEM_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_halt,
    input  logic [DATA_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              wb_en,
    output logic              wb_bubble,
    output logic [DATA_W-1:0] wb_mem_data,
    output logic              halted,
    output logic [15:0]       acc_cnt,
    output logic              timeout_err
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WCNT_W = 4;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              access_c;
    logic              start_c;
    logic              tmo_c;
    logic              req_we;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    assign access_c  = in_valid & (in_mem_read | in_mem_write);
    assign start_c   = (state == S_IDLE) & ~halted & access_c;
    assign mem_we    = req_we;
    assign mem_addr  = req_addr;
    assign mem_wdata = req_wdata;

`ifdef MEM_TIMEOUT_EN
    localparam logic [WCNT_W-1:0] TMO_LAST = WCNT_W'(TIMEOUT - 1);

    logic [WCNT_W-1:0] wait_cnt;
    logic              tmo_err;

    // An ack in the timeout cycle wins, so the timeout only fires without ack.
    assign tmo_c       = (state == S_WAIT) & ~mem_ack & (wait_cnt == TMO_LAST);
    assign timeout_err = tmo_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            tmo_err  <= 1'b0;
        end else begin
            if (start_c) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT && !mem_ack) begin
                wait_cnt <= wait_cnt + WCNT_W'(1);
            end
            if (tmo_c) begin
                tmo_err <= 1'b1;
            end
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo  = ^(32'(TIMEOUT));
    assign tmo_c       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start_c) state_nxt = S_WAIT;
            S_WAIT: if (mem_ack || tmo_c) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake and MEM/WB control; held at reset values while rst_n is low.
    always_comb begin
        mem_req     = 1'b0;
        stall       = 1'b0;
        wb_en       = 1'b1;
        wb_bubble   = 1'b1;
        wb_mem_data = '0;
        if (!rst_n) begin
            wb_bubble = 1'b1;
        end else if (halted) begin
            stall = 1'b1;
            wb_en = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (access_c) begin
                        stall = 1'b1;
                    end else begin
                        wb_bubble = ~in_valid;
                    end
                end
                S_WAIT: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        wb_bubble   = 1'b0;
                        wb_mem_data = req_we ? '0 : mem_rdata;
                    end else if (tmo_c) begin
                        wb_bubble = 1'b0;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: stall = 1'b1;
            endcase
        end
    end

    // Request capture, access counter and sticky halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            acc_cnt   <= '0;
            halted    <= 1'b0;
        end else begin
            if (start_c) begin
                req_we    <= in_mem_write;
                req_addr  <= in_addr;
                req_wdata <= in_wdata;
            end
            if (state == S_WAIT && mem_ack) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
            if (in_valid && in_halt && !stall) begin
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl: loads, stores, bubbles, halt, async reset
// and (when MEM_TIMEOUT_EN is defined) the WAIT timeout.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_mem_read;
    logic        in_mem_write;
    logic        in_halt;
    logic [15:0] in_addr;
    logic [15:0] in_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        stall;
    logic        wb_en;
    logic        wb_bubble;
    logic [15:0] wb_mem_data;
    logic        halted;
    logic [15:0] acc_cnt;
    logic        timeout_err;

    int n_vec;
    int n_err;
    int stall_hi;
    logic [15:0] exp_cnt;

    mem_access_ctrl #(.DATA_W(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_halt(in_halt), .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .wb_en(wb_en), .wb_bubble(wb_bubble), .wb_mem_data(wb_mem_data),
        .halted(halted), .acc_cnt(acc_cnt), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic h,
                         input logic [15:0] a, input logic [15:0] d);
        in_valid     = v;
        in_mem_read  = rd;
        in_mem_write = wr;
        in_halt      = h;
        in_addr      = a;
        in_wdata     = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_cnt = 16'd0;
        rst_n = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 16'h0000;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        settle();
        check("rst_mem_req", 16'(mem_req), 16'd0);
        check("rst_mem_we", 16'(mem_we), 16'd0);
        check("rst_stall", 16'(stall), 16'd0);
        check("rst_halted", 16'(halted), 16'd0);
        check("rst_tmo", 16'(timeout_err), 16'd0);
        check("rst_addr", mem_addr, 16'h0000);
        check("rst_wdata", mem_wdata, 16'h0000);
        check("rst_wbdata", wb_mem_data, 16'h0000);
        check("rst_cnt", acc_cnt, 16'h0000);
        check("rst_wb_en", 16'(wb_en), 16'd1);
        check("rst_bubble", 16'(wb_bubble), 16'd1);
        #2 rst_n = 1'b1;

        // Load at 0x0040: three WAIT cycles without ack, then ack with 0xBEEF
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000);
        settle();
        check("ld_cap_stall", 16'(stall), 16'd1);
        check("ld_cap_bubble", 16'(wb_bubble), 16'd1);
        check("ld_cap_req", 16'(mem_req), 16'd0);
        stall_hi = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            settle();
            check("ld_wait_req", 16'(mem_req), 16'd1);
            check("ld_wait_addr", mem_addr, 16'h0040);
            check("ld_wait_we", 16'(mem_we), 16'd0);
            check("ld_wait_bubble", 16'(wb_bubble), 16'd1);
            stall_hi += int'(stall);
        end
        step();
        mem_ack = 1'b1;
        mem_rdata = 16'hBEEF;
        settle();
        check("ld_ack_stall", 16'(stall), 16'd0);
        check("ld_ack_bubble", 16'(wb_bubble), 16'd0);
        check("ld_ack_wb_en", 16'(wb_en), 16'd1);
        check("ld_ack_data", wb_mem_data, 16'hBEEF);
        check("ld_stall_cycles", 16'(stall_hi), 16'd4);

        // Store 0x00A5 -> 0x1234, immediate ack
        step();
        mem_ack = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h00A5);
        settle();
        check("ld_cnt", acc_cnt, 16'd1);
        check("st_cap_stall", 16'(stall), 16'd1);
        check("st_cap_req", 16'(mem_req), 16'd0);
        step();
        mem_ack = 1'b1;
        mem_rdata = 16'h7777;
        settle();
        check("st_req", 16'(mem_req), 16'd1);
        check("st_we", 16'(mem_we), 16'd1);
        check("st_addr", mem_addr, 16'h1234);
        check("st_wdata", mem_wdata, 16'h00A5);
        check("st_ack_stall", 16'(stall), 16'd0);
        check("st_ack_data", wb_mem_data, 16'h0000);

        // ADD with a stray ack in IDLE, then load acked after one WAIT cycle, then ADD
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        mem_ack = 1'b1;
        mem_rdata = 16'hFFFF;
        settle();
        check("st_cnt", acc_cnt, 16'd2);
        check("add1_stall", 16'(stall), 16'd0);
        check("add1_bubble", 16'(wb_bubble), 16'd0);
        check("add1_data", wb_mem_data, 16'h0000);
        check("add1_req", 16'(mem_req), 16'd0);
        step();
        mem_ack = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0022, 16'h0000);
        settle();
        check("stray_cnt", acc_cnt, 16'd2);
        check("b2b_cap_bubble", 16'(wb_bubble), 16'd1);
        step();
        settle();
        check("b2b_wait_bubble", 16'(wb_bubble), 16'd1);
        check("b2b_wait_stall", 16'(stall), 16'd1);
        check("b2b_wait_addr", mem_addr, 16'h0022);
        step();
        mem_ack = 1'b1;
        mem_rdata = 16'h1357;
        settle();
        check("b2b_ack_bubble", 16'(wb_bubble), 16'd0);
        check("b2b_ack_data", wb_mem_data, 16'h1357);
        step();
        mem_ack = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        settle();
        check("add2_stall", 16'(stall), 16'd0);
        check("add2_bubble", 16'(wb_bubble), 16'd0);
        check("b2b_cnt", acc_cnt, 16'd3);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        settle();
        check("nop_bubble", 16'(wb_bubble), 16'd1);
        check("nop_stall", 16'(stall), 16'd0);

        // Asynchronous reset while a load waits for ack
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000);
        step();
        check("mid_req_pre", 16'(mem_req), 16'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_req", 16'(mem_req), 16'd0);
        check("mid_stall", 16'(stall), 16'd0);
        check("mid_cnt", acc_cnt, 16'h0000);
        check("mid_bubble", 16'(wb_bubble), 16'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1 rst_n = 1'b1;
        step();
        mem_ack = 1'b1;
        mem_rdata = 16'hAAAA;
        settle();
        check("post_rst_data", wb_mem_data, 16'h0000);
        check("post_rst_req", 16'(mem_req), 16'd0);
        step();
        mem_ack = 1'b0;
        settle();
        check("post_rst_cnt", acc_cnt, 16'h0000);

        // Read and write both set: treated as a store
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0200, 16'h5A5A);
        settle();
        check("rw_cap_stall", 16'(stall), 16'd1);
        step();
        mem_ack = 1'b1;
        mem_rdata = 16'h1111;
        settle();
        check("rw_we", 16'(mem_we), 16'd1);
        check("rw_wdata", mem_wdata, 16'h5A5A);
        check("rw_data", wb_mem_data, 16'h0000);
        step();
        mem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        settle();
        exp_cnt = 16'd1;
        check("rw_cnt", acc_cnt, exp_cnt);

`ifdef MEM_TIMEOUT_EN
        // Ack on the 15th WAIT cycle beats the timeout
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0300, 16'h0000);
        settle();
        stall_hi = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            settle();
            stall_hi += int'(stall);
        end
        check("tmo_a_stall14", 16'(stall_hi), 16'd14);
        step();
        mem_ack = 1'b1;
        mem_rdata = 16'h0F0F;
        settle();
        check("tmo_a_stall", 16'(stall), 16'd0);
        check("tmo_a_data", wb_mem_data, 16'h0F0F);
        step();
        mem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        settle();
        exp_cnt = 16'd2;
        check("tmo_a_err", 16'(timeout_err), 16'd0);
        check("tmo_a_cnt", acc_cnt, exp_cnt);

        // No ack: completes on the 15th WAIT cycle with error
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0400, 16'h0000);
        mem_rdata = 16'h9999;
        settle();
        stall_hi = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            settle();
            stall_hi += int'(stall);
        end
        check("tmo_b_stall14", 16'(stall_hi), 16'd14);
        step();
        settle();
        check("tmo_b_stall", 16'(stall), 16'd0);
        check("tmo_b_bubble", 16'(wb_bubble), 16'd0);
        check("tmo_b_data", wb_mem_data, 16'h0000);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        settle();
        check("tmo_b_err", 16'(timeout_err), 16'd1);
        check("tmo_b_cnt", acc_cnt, exp_cnt);
        check("tmo_b_idle", 16'(mem_req), 16'd0);
`else
        check("tmo_tied", 16'(timeout_err), 16'd0);
`endif

        // Halt retires, then a following load is frozen out
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        settle();
        check("hlt_stall", 16'(stall), 16'd0);
        check("hlt_bubble", 16'(wb_bubble), 16'd0);
        check("hlt_pre", 16'(halted), 16'd0);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0500, 16'h0000);
        mem_ack = 1'b1;
        settle();
        check("hlt_halted", 16'(halted), 16'd1);
        check("hlt_stall_on", 16'(stall), 16'd1);
        check("hlt_wb_en", 16'(wb_en), 16'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            settle();
            check("hlt_no_req", 16'(mem_req), 16'd0);
            check("hlt_hold_stall", 16'(stall), 16'd1);
            check("hlt_hold_wb_en", 16'(wb_en), 16'd0);
        end
        check("hlt_cnt", acc_cnt, exp_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
